// File: rtl/cpu_fpga_pkg.sv
// Shared types and constants for the FPGA demo microprogram sequencer.
// Holds the sequencer state encoding and the legacy demo microinstructions.
package cpu_fpga_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_ISSUE = 2'd2,
        ST_HALT  = 2'd3
    } seq_state_t;

    localparam logic [27:0] MIR_NOP = 28'h0000000;

    // Legacy switch-decoded demo program: load/show pairs for c, b and RAM.
    localparam logic [27:0] MI_LOAD_C     = 28'h0C40080;
    localparam logic [27:0] MI_SHOW_C     = 28'h0004050;
    localparam logic [27:0] MI_SHOW_B     = 28'h0004070;
    localparam logic [27:0] MI_LOAD_B     = 28'h0C20080;
    localparam logic [27:0] MI_LOAD_RAM   = 28'h0C10080;
    localparam logic [27:0] MI_SHOW_RAM   = 28'h0004090;
    localparam logic [27:0] MI_STORE_RAM  = 28'h0008100;
    localparam logic [27:0] MI_SHOW_RAMW  = 28'h00040B0;
    localparam logic [27:0] MI_CLEAR      = 28'h0800000;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus level debouncer for a raw board button.
// Emits a single-cycle pulse when a new high level has been stable for CYCLES.
module btn_debounce #(
    parameter int CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic press_pulse
);

    localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;

    logic          r_s0;
    logic          r_s1;
    logic          r_level;
    logic          r_pulse;
    logic [CW-1:0] r_cnt;

    // The accepted level only flips after CYCLES consecutive samples of the
    // opposite value, so releases are debounced exactly like presses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s0    <= 1'b0;
            r_s1    <= 1'b0;
            r_level <= 1'b0;
            r_pulse <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_s0    <= btn;
            r_s1    <= r_s0;
            r_pulse <= 1'b0;
            if (r_s1 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CW'(CYCLES - 1)) begin
                r_cnt   <= '0;
                r_level <= r_s1;
                r_pulse <= r_s1;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign press_pulse = r_pulse;

endmodule

// File: rtl/cpu_fpga_seq.sv
// Writable microprogram sequencer feeding the cpu core's mir input, stepped
// by a button or free-running at a divided rate, with LED bus windows.
module cpu_fpga_seq
    import cpu_fpga_pkg::*;
#(
    parameter int MIR_W           = 28,
    parameter int DEPTH           = 16,
    parameter int DATA_W          = 32,
    parameter int LED_W           = 3,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int RUN_DIV         = 25_000_000,
    localparam int AW             = $clog2(DEPTH),
    localparam int WSW            = $clog2(DATA_W / LED_W)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 btn_step,
    input  logic                 btn_run,
    input  logic                 loop_en,
    input  logic [AW-1:0]        prog_last,
    input  logic                 prog_we,
    input  logic [AW-1:0]        prog_addr,
    input  logic [MIR_W-1:0]     prog_data,
    input  logic [WSW-1:0]       win_sel,
    input  logic [DATA_W-1:0]    on_c,
    input  logic [DATA_W-1:0]    on_b,
    input  logic [DATA_W-1:0]    on_ram_read,
    input  logic [DATA_W-1:0]    on_ram_write,
    output logic [MIR_W-1:0]     mir,
    output logic [AW-1:0]        pc,
    output logic [1:0]           state,
    output logic [4*LED_W-1:0]   led
);

    localparam int DW = (RUN_DIV > 2) ? $clog2(RUN_DIV) : 1;

    logic                w_step;
    logic                w_run;
    logic                w_we;
    logic [MIR_W-1:0]    w_rd;

    seq_state_t          r_state;
    seq_state_t          r_ret;
    logic [AW-1:0]       r_pc;
    logic [MIR_W-1:0]    r_mir;
    logic [DW-1:0]       r_div;
    logic [4*LED_W-1:0]  r_led;
    logic [MIR_W-1:0]    r_mem [DEPTH];

    btn_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_step (
        .clk(clk), .rst_n(rst_n), .btn(btn_step), .press_pulse(w_step)
    );

    btn_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_run (
        .clk(clk), .rst_n(rst_n), .btn(btn_run), .press_pulse(w_run)
    );

    assign w_we = prog_we && (r_state == ST_IDLE || r_state == ST_HALT);

    always_ff @(posedge clk) begin
        if (w_we) r_mem[prog_addr] <= prog_data;
    end

    // Bypass lets a write land in the same cycle the ISSUE is being launched.
    assign w_rd = (w_we && prog_addr == r_pc) ? prog_data : r_mem[r_pc];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_ret   <= ST_IDLE;
            r_pc    <= '0;
            r_mir   <= '0;
            r_div   <= '0;
        end else begin
            r_mir <= MIR_W'(MIR_NOP);
            case (r_state)
                ST_IDLE: begin
                    if (w_run) begin
                        r_state <= ST_RUN;
                        r_div   <= '0;
                    end else if (w_step) begin
                        r_state <= ST_ISSUE;
                        r_ret   <= ST_IDLE;
                        r_mir   <= w_rd;
                    end
                end
                ST_RUN: begin
                    if (w_run) begin
                        r_state <= ST_IDLE;
                    end else if (r_div == DW'(RUN_DIV - 1)) begin
                        r_div   <= '0;
                        r_state <= ST_ISSUE;
                        r_ret   <= ST_RUN;
                        r_mir   <= w_rd;
                    end else begin
                        r_div <= r_div + DW'(1);
                    end
                end
                ST_ISSUE: begin
                    r_div <= '0;
                    r_pc  <= (r_pc == prog_last) ? '0 : r_pc + AW'(1);
                    // A run press landing on the ISSUE cycle still toggles run.
                    if (r_pc == prog_last && !loop_en)
                        r_state <= ST_HALT;
                    else if (w_run)
                        r_state <= (r_ret == ST_RUN) ? ST_IDLE : ST_RUN;
                    else
                        r_state <= r_ret;
                end
                ST_HALT: begin
                    if (w_run || w_step) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    function automatic logic [LED_W-1:0] f_win(input logic [DATA_W-1:0] bus,
                                               input logic [WSW-1:0] sel);
        logic [DATA_W-1:0] sh;
        sh = bus >> (int'(sel) * LED_W);
        return sh[LED_W-1:0];
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_led <= '0;
        else        r_led <= {f_win(on_c, win_sel), f_win(on_b, win_sel),
                              f_win(on_ram_read, win_sel), f_win(on_ram_write, win_sel)};
    end

    assign mir   = r_mir;
    assign pc    = r_pc;
    assign state = r_state;
    assign led   = r_led;

endmodule

// File: tb/tb_cpu_fpga_seq.sv
// Directed self-checking bench for cpu_fpga_seq with short debounce and run
// divider so stepping, run mode, write gating, reset and LEDs fit in a few hundred cycles.
module tb_cpu_fpga_seq;

    localparam int MIR_W  = 28;
    localparam int AW     = 4;
    localparam int DATA_W = 32;
    localparam int WSW    = 4;

    localparam logic [MIR_W-1:0] E0  = 28'h0C40080;
    localparam logic [MIR_W-1:0] E1  = 28'h0004050;
    localparam logic [MIR_W-1:0] E2  = 28'h0004070;
    localparam logic [MIR_W-1:0] NEW = 28'h0ABCDE1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              btn_step = 1'b0;
    logic              btn_run = 1'b0;
    logic              loop_en = 1'b0;
    logic [AW-1:0]     prog_last = '0;
    logic              prog_we = 1'b0;
    logic [AW-1:0]     prog_addr = '0;
    logic [MIR_W-1:0]  prog_data = '0;
    logic [WSW-1:0]    win_sel = '0;
    logic [DATA_W-1:0] on_c = '0;
    logic [DATA_W-1:0] on_b = '0;
    logic [DATA_W-1:0] on_ram_read = '0;
    logic [DATA_W-1:0] on_ram_write = '0;
    logic [MIR_W-1:0]  mir;
    logic [AW-1:0]     pc;
    logic [1:0]        state;
    logic [11:0]       led;

    cpu_fpga_seq #(
        .MIR_W(28), .DEPTH(16), .DATA_W(32), .LED_W(3),
        .DEBOUNCE_CYCLES(4), .RUN_DIV(5)
    ) dut (
        .clk(clk), .rst_n(rst_n), .btn_step(btn_step), .btn_run(btn_run),
        .loop_en(loop_en), .prog_last(prog_last), .prog_we(prog_we),
        .prog_addr(prog_addr), .prog_data(prog_data), .win_sel(win_sel),
        .on_c(on_c), .on_b(on_b), .on_ram_read(on_ram_read),
        .on_ram_write(on_ram_write), .mir(mir), .pc(pc), .state(state), .led(led)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int issue_n = 0;
    int nz_n = 0;
    int misalign = 0;
    logic [MIR_W-1:0] iss_mir[$];
    int iss_cyc[$];

    always @(negedge clk) begin
        cyc++;
        if (state == 2'd2) begin
            issue_n++;
            iss_mir.push_back(mir);
            iss_cyc.push_back(cyc);
        end
        if (mir != '0) nz_n++;
        if ((mir != '0) != (state == 2'd2)) misalign++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic press(input logic s, input logic r);
        btn_step = s;
        btn_run  = r;
        tick(10);
        btn_step = 1'b0;
        btn_run  = 1'b0;
        tick(10);
    endtask

    task automatic write_mem(input logic [AW-1:0] a, input logic [MIR_W-1:0] d);
        prog_addr = a;
        prog_data = d;
        prog_we   = 1'b1;
        tick(1);
        prog_we   = 1'b0;
    endtask

    task automatic rst_pulse();
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        tick(1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int  base;
        int  n;
        bit  found;

        #3;
        chk("rst_mir", 32'(mir), 32'd0);
        chk("rst_pc", 32'(pc), 32'd0);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_led", 32'(led), 32'd0);
        tick(3);
        rst_n = 1'b1;
        tick(2);

        write_mem(4'd0, E0);
        write_mem(4'd1, E1);
        write_mem(4'd2, E2);
        prog_last = 4'd2;
        loop_en   = 1'b0;

        press(1'b1, 1'b0);
        chk("step1_pc", 32'(pc), 32'd1);
        chk("step1_state", 32'(state), 32'd0);
        press(1'b1, 1'b0);
        press(1'b1, 1'b0);
        chk("step_count", 32'(issue_n), 32'd3);
        chk("step_mir0", 32'(iss_mir[0]), 32'(E0));
        chk("step_mir1", 32'(iss_mir[1]), 32'(E1));
        chk("step_mir2", 32'(iss_mir[2]), 32'(E2));
        chk("step_one_cycle", 32'(nz_n), 32'd3);
        chk("step_align", 32'(misalign), 32'd0);
        chk("halt_state", 32'(state), 32'd3);
        chk("halt_pc", 32'(pc), 32'd0);

        press(1'b1, 1'b0);
        chk("halt_exit_state", 32'(state), 32'd0);
        chk("halt_exit_noissue", 32'(issue_n), 32'd3);

        // bounce: 1-0-1 then held
        btn_step = 1'b1; tick(1);
        btn_step = 1'b0; tick(1);
        btn_step = 1'b1; tick(10);
        btn_step = 1'b0; tick(10);
        chk("bounce_count", 32'(issue_n), 32'd4);
        chk("bounce_mir", 32'(iss_mir[3]), 32'(E0));
        chk("bounce_pc", 32'(pc), 32'd1);

        prog_last = 4'd1;
        loop_en   = 1'b1;
        press(1'b1, 1'b0);
        chk("loop_step_mir", 32'(iss_mir[4]), 32'(E1));
        chk("loop_step_pc", 32'(pc), 32'd0);
        chk("loop_step_state", 32'(state), 32'd0);

        base = issue_n;
        btn_run = 1'b1; tick(10);
        btn_run = 1'b0; tick(30);
        press(1'b0, 1'b1);
        n = issue_n - base;
        chk("run_enough", 32'(n >= 4), 32'd1);
        for (int i = 0; i < n; i++) begin
            chk("run_mir", 32'(iss_mir[base + i]), (i % 2 == 1) ? 32'(E1) : 32'(E0));
            if (i > 0) chk("run_gap", 32'(iss_cyc[base + i] - iss_cyc[base + i - 1]), 32'd6);
        end
        chk("pause_state", 32'(state), 32'd0);
        chk("pause_pc", 32'(pc), 32'(n % 2));
        base = issue_n;
        tick(12);
        chk("pause_hold", 32'(issue_n), 32'(base));

        base  = issue_n;
        found = 1'b0;
        btn_step = 1'b1;
        btn_run  = 1'b1;
        for (int k = 0; k < 20 && !found; k++) begin
            tick(1);
            if (state == 2'd1) found = 1'b1;
        end
        chk("both_to_run", 32'(found), 32'd1);
        chk("both_noissue", 32'(issue_n), 32'(base));
        btn_step = 1'b0;
        btn_run  = 1'b0;
        tick(10);
        press(1'b0, 1'b1);
        chk("both_pause", 32'(state), 32'd0);

        rst_pulse();
        chk("rst2_pc", 32'(pc), 32'd0);
        found = 1'b0;
        btn_run = 1'b1;
        for (int k = 0; k < 20 && !found; k++) begin
            tick(1);
            if (state == 2'd1) found = 1'b1;
        end
        chk("we_run_entered", 32'(found), 32'd1);
        write_mem(4'd0, NEW);
        btn_run = 1'b0;
        tick(10);
        press(1'b0, 1'b1);
        rst_pulse();
        press(1'b1, 1'b0);
        chk("we_run_ignored", 32'(iss_mir[issue_n - 1]), 32'(E0));
        rst_pulse();
        write_mem(4'd0, NEW);
        press(1'b1, 1'b0);
        chk("we_idle_taken", 32'(iss_mir[issue_n - 1]), 32'(NEW));

        found = 1'b0;
        btn_step = 1'b1;
        for (int k = 0; k < 20 && !found; k++) begin
            tick(1);
            if (state == 2'd2) found = 1'b1;
        end
        chk("pre_rst_issue", 32'(found), 32'd1);
        chk("pre_rst_mir", 32'(mir), 32'(E1));
        rst_n    = 1'b0;
        btn_step = 1'b0;
        #1;
        chk("async_rst_mir", 32'(mir), 32'd0);
        chk("async_rst_state", 32'(state), 32'd0);
        chk("async_rst_pc", 32'(pc), 32'd0);
        tick(10);
        rst_n = 1'b1;
        tick(2);
        press(1'b1, 1'b0);
        chk("mem_kept", 32'(iss_mir[issue_n - 1]), 32'(NEW));

        win_sel      = 4'd1;
        on_c         = 32'h38;
        on_b         = 32'h0;
        on_ram_read  = 32'h8;
        on_ram_write = 32'h30;
        #1;
        chk("led_lag", 32'(led), 32'd0);
        tick(1);
        chk("led_c_win", 32'(led[11:9]), 32'd7);
        chk("led_all", 32'(led), 32'hE0E);
        win_sel      = 4'd10;
        on_c         = 32'hC000_0000;
        on_b         = 32'hFFFF_FFFF;
        on_ram_read  = 32'h0;
        on_ram_write = 32'h2000_0000;
        tick(1);
        chk("led_edge_win", 32'(led), 32'h6C0);
        win_sel      = 4'd15;
        on_c         = 32'hFFFF_FFFF;
        on_ram_read  = 32'hFFFF_FFFF;
        on_ram_write = 32'hFFFF_FFFF;
        tick(1);
        chk("led_beyond", 32'(led), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_fpga_seq.md
# cpu_fpga_seq

Parametrised microprogram sequencer for the FPGA demo board, replacing the fixed switch-to-microinstruction decode. It holds a writable microprogram of `DEPTH` entries and issues them to the `cpu` core's `mir` input, one per debounced step press or automatically at a divided rate. It also drives a window of the core's four observation buses onto LEDs. The board top instantiates this block next to `cpu`.

## Interface
- `MIR_W`, 28: microinstruction width
- `DEPTH`, 16: microprogram entries, power of two; `AW = $clog2(DEPTH)`
- `DATA_W`, 32: width of observed buses
- `LED_W`, 3: LEDs per observed bus
- `DEBOUNCE_CYCLES`, 1_000_000: stable cycles a button needs to register
- `RUN_DIV`, 25_000_000: cycles between issues in run mode, ≥2
- `clk  in  1`: board clock
- `rst_n  in  1`: asynchronous, active-low reset
- `btn_step  in  1`: raw step button
- `btn_run  in  1`: raw run/pause toggle button
- `loop_en  in  1`: wrap to entry 0 after `prog_last` instead of halting
- `prog_last  in  AW`: index of last valid entry
- `prog_we  in  1`: microprogram write strobe
- `prog_addr  in  AW`: write address
- `prog_data  in  MIR_W`: write data
- `win_sel  in  $clog2(DATA_W/LED_W)`: LED bit window select
- `on_c`, `on_b`, `on_ram_read`, `on_ram_write  in  DATA_W`: core observation buses
- `mir  out  MIR_W`: microinstruction to core; 0 is NOP
- `pc  out  AW`: next entry to issue
- `state  out  2`: IDLE=0, RUN=1, ISSUE=2, HALT=3
- `led  out  4*LED_W`: {c, b, ram_read, ram_write} windows, MSB first

## Operation
- Buttons: two-flop sync, then debounce. One-cycle press pulse when the synced level has been stable high for `DEBOUNCE_CYCLES`. Release must also be stable before the next press counts.
- IDLE: `mir`=0.
  - step pulse → ISSUE, returns to IDLE.
  - run pulse → RUN, with the divider cleared.
- RUN: divider counts 0..`RUN_DIV`-1.
  - At terminal count → ISSUE, returns to RUN.
  - Run pulse → IDLE (pause, `pc` kept).
  - Step pulse is ignored.
- ISSUE: lasts one cycle; `mir`=mem[`pc`].
  - If `pc`==`prog_last`: with `loop_en`, `pc`←0 and go to the return state; otherwise `pc`←0 and go to HALT.
  - Else `pc`←`pc`+1 and go to the return state.
- HALT: `mir`=0. A step or run pulse → IDLE.
- Simultaneous step and run pulses: run wins.
- `prog_we` is honoured only in IDLE/HALT and ignored in RUN/ISSUE. Writes beyond `prog_last` are legal.
- Memory is not reset; `rst_n` leaves contents intact.
- `prog_last` ≥ `DEPTH` is impossible by width. Changing it mid-RUN takes effect at the next ISSUE compare.
- LEDs: each window = bus[`win_sel*LED_W +: LED_W`]; window bits ≥ `DATA_W` read 0.

## Timing
- Reset values: `mir`=0, `pc`=0, `state`=IDLE, `led`=0, divider/debounce counters 0, sync flops 0.
- `mir`, `led`, `pc`, `state` are registered.
- Press pulse in cycle P → ISSUE in cycle P+1 → `mir` nonzero (if entry nonzero) in exactly cycle P+1, then 0.
- RUN issue period is exactly `RUN_DIV`+1 cycles (divider plus the ISSUE cycle).
- Write in cycle W is readable by an ISSUE in cycle W+1.
- `led` is one cycle behind the `on_*`/`win_sel` inputs.
- Reset asserted mid-ISSUE: `mir` drops to 0 asynchronously and never stays active past reset.

## Structure
- Package `cpu_fpga_pkg`:
  - state enum IDLE/RUN/ISSUE/HALT
  - `MIR_NOP` = 0
  - the nine legacy demo microinstructions as named constants (c/b/ram load-and-show pairs) for bench and default loader use
- Sub-module `btn_debounce`: param `CYCLES`, ports `clk`, `rst_n`, `btn`, `press_pulse`. Instantiated twice.
- Memory: plain reg array, inferred distributed RAM.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4, `RUN_DIV`=5, `DEPTH`=16.
- Load entries 0..2 = 28'h0C40080, 28'h0004050, 28'h0004070, `prog_last`=2, `loop_en`=0. Three step presses → `mir` shows each value for one cycle, in order; after the third press, state=HALT and `pc`=0.
- Button bounce 1-0-1 inside 3 cycles, then held 10 cycles → exactly one press pulse and one ISSUE.
- Run with `loop_en`=1, `prog_last`=1 → issues at 6-cycle spacing: entry0, entry1, entry0, …. A run press then pauses: IDLE, `pc` retained.
- Step and run pulses in the same cycle from IDLE → RUN, no ISSUE that cycle.
- `prog_we` during RUN at address 0 → memory unchanged. Same write in IDLE → next step issues the new value.
- `rst_n` low during ISSUE → `mir`=0 immediately, `pc`=0, state=IDLE; memory contents are preserved on the next step. With `win_sel`=1 and `on_c`=32'h38 → `led[11:9]`=3'b111.
